// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: opcode/flags/ready from the datapath side, control strobes,
// error code and retired count back to it.
interface multicycle_control_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic [1:0]       aluop;
  logic             Branch;
  logic             MemRead;
  logic             MemtoReg;
  logic             MemWrite;
  logic             ALUSrc;
  logic             RegWrite;
  logic             Jump;
  logic             PCWrite;
  logic             IRWrite;
  logic             IorD;
  logic [1:0]       err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output aluop, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
           Jump, PCWrite, IRWrite, IorD, err, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  aluop, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
           Jump, PCWrite, IRWrite, IorD, err, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V main control: Moore FSM sequencing fetch/decode/execute/memory/
// write-back, with memory-ready stalls, timeout and illegal-opcode errors, retire counter.
module multicycle_control_unit #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned TIMEOUT         = 16,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master bus
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);
  localparam bit TO_EN = (TIMEOUT != 0);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXEC_R    = 4'd3;
  localparam logic [3:0] S_EXEC_I    = 4'd4;
  localparam logic [3:0] S_WB_ALU    = 4'd5;
  localparam logic [3:0] S_MEM_ADDR  = 4'd6;
  localparam logic [3:0] S_MEM_READ  = 4'd7;
  localparam logic [3:0] S_MEM_WRITE = 4'd8;
  localparam logic [3:0] S_WB_MEM    = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JAL       = 4'd11;
  localparam logic [3:0] S_ILLEGAL   = 4'd12;
  localparam logic [3:0] S_HALT      = 4'd13;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              itype_q, itype_d;

  logic [1:0] err_new;
  logic       retire;
  logic       timeout_c;
  logic [1:0] aluop_c;
  logic       branch_c, memread_c, memtoreg_c, memwrite_c, alusrc_c;
  logic       regwrite_c, jump_c, pcwrite_c, irwrite_c, iord_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      itype_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      itype_q <= itype_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    itype_d    = itype_q;
    err_new    = ERR_NONE;
    retire     = 1'b0;
    aluop_c    = 2'b00;
    branch_c   = 1'b0;
    memread_c  = 1'b0;
    memtoreg_c = 1'b0;
    memwrite_c = 1'b0;
    alusrc_c   = 1'b0;
    regwrite_c = 1'b0;
    jump_c     = 1'b0;
    pcwrite_c  = 1'b0;
    irwrite_c  = 1'b0;
    iord_c     = 1'b0;
    // A ready in the last allowed wait cycle still completes the access
    timeout_c  = TO_EN && !bus.mem_ready && (wait_q == WAIT_LAST);

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        memread_c = 1'b1;
        irwrite_c = bus.mem_ready;
        pcwrite_c = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_HALT;
          err_new = ERR_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        itype_d = (bus.opcode == OP_I);
        case (bus.opcode)
          OP_R:           state_d = S_EXEC_R;
          OP_I:           state_d = S_EXEC_I;
          OP_LOAD,
          OP_STOR:        state_d = S_MEM_ADDR;
          OP_BR:          state_d = S_BRANCH;
          OP_JAL:         state_d = S_JAL;
          default: begin
            state_d = S_ILLEGAL;
            err_new = ERR_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        aluop_c = 2'b10;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        aluop_c  = 2'b11;
        alusrc_c = 1'b1;
        state_d  = S_WB_ALU;
      end
      S_WB_ALU: begin
        // ALU controls stay as in the EXEC state so the result remains valid
        regwrite_c = 1'b1;
        aluop_c    = itype_q ? 2'b11 : 2'b10;
        alusrc_c   = itype_q;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEM_ADDR: begin
        alusrc_c = 1'b1;
        state_d  = (bus.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_WB_MEM;
        end else if (timeout_c) begin
          state_d = S_HALT;
          err_new = ERR_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_MEM_WRITE: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout_c) begin
          state_d = S_HALT;
          err_new = ERR_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB_MEM: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        branch_c  = 1'b1;
        aluop_c   = 2'b01;
        pcwrite_c = bus.zero;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_JAL: begin
        jump_c     = 1'b1;
        pcwrite_c  = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_ILLEGAL: state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase

    // Every state change restarts the memory wait window
    if (state_d != state_q) wait_d = '0;
    if (err_q == ERR_NONE) err_d = err_new;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  assign bus.aluop       = aluop_c;
  assign bus.Branch      = branch_c;
  assign bus.MemRead     = memread_c;
  assign bus.MemtoReg    = memtoreg_c;
  assign bus.MemWrite    = memwrite_c;
  assign bus.ALUSrc      = alusrc_c;
  assign bus.RegWrite    = regwrite_c;
  assign bus.Jump        = jump_c;
  assign bus.PCWrite     = pcwrite_c;
  assign bus.IRWrite     = irwrite_c;
  assign bus.IorD        = iord_c;
  assign bus.err         = err_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: four parameterisations share one stimulus;
// table-driven instruction mix, randomized trace model, and directed corner cases.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  // Control word: {aluop, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, PCWrite, IRWrite, IorD}
  localparam logic [11:0] W_IORD = 12'h001;
  localparam logic [11:0] W_IRW  = 12'h002;
  localparam logic [11:0] W_PCW  = 12'h004;
  localparam logic [11:0] W_JMP  = 12'h008;
  localparam logic [11:0] W_RW   = 12'h010;
  localparam logic [11:0] W_ASRC = 12'h020;
  localparam logic [11:0] W_MW   = 12'h040;
  localparam logic [11:0] W_M2R  = 12'h080;
  localparam logic [11:0] W_MR   = 12'h100;
  localparam logic [11:0] W_BR   = 12'h200;
  localparam logic [11:0] A_BR   = 12'h400;
  localparam logic [11:0] A_R    = 12'h800;
  localparam logic [11:0] A_I    = 12'hC00;
  localparam logic [11:0] W_FETCH = W_MR | W_IRW | W_PCW;

  typedef struct {
    logic [6:0]  op;
    logic        z;
    int          lat;
    logic [11:0] last;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic       zero;
  logic [6:0] opcode;
  int checks = 0;
  int errors = 0;
  int model_retired;

  logic [11:0] wq[$];
  logic        rq[$];
  logic [11:0] cw [4];
  logic [1:0]  er [4];
  logic [31:0] ic [4];

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.CNT_W(32)) if0 ();
  multicycle_control_unit_if #(.CNT_W(32)) if1 ();
  multicycle_control_unit_if #(.CNT_W(32)) if2 ();
  multicycle_control_unit_if #(.CNT_W(3))  if3 ();

  assign if0.opcode = opcode; assign if0.zero = zero; assign if0.mem_ready = mem_ready;
  assign if1.opcode = opcode; assign if1.zero = zero; assign if1.mem_ready = mem_ready;
  assign if2.opcode = opcode; assign if2.zero = zero; assign if2.mem_ready = mem_ready;
  assign if3.opcode = opcode; assign if3.zero = zero; assign if3.mem_ready = mem_ready;

  multicycle_control_unit #(.CNT_W(32), .TIMEOUT(16), .HALT_ON_ILLEGAL(1'b1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  multicycle_control_unit #(.CNT_W(32), .TIMEOUT(4), .HALT_ON_ILLEGAL(1'b1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  multicycle_control_unit #(.CNT_W(32), .TIMEOUT(16), .HALT_ON_ILLEGAL(1'b0))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  multicycle_control_unit #(.CNT_W(3), .TIMEOUT(16), .HALT_ON_ILLEGAL(1'b1))
    u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign cw[0] = {if0.aluop, if0.Branch, if0.MemRead, if0.MemtoReg, if0.MemWrite, if0.ALUSrc,
                  if0.RegWrite, if0.Jump, if0.PCWrite, if0.IRWrite, if0.IorD};
  assign cw[1] = {if1.aluop, if1.Branch, if1.MemRead, if1.MemtoReg, if1.MemWrite, if1.ALUSrc,
                  if1.RegWrite, if1.Jump, if1.PCWrite, if1.IRWrite, if1.IorD};
  assign cw[2] = {if2.aluop, if2.Branch, if2.MemRead, if2.MemtoReg, if2.MemWrite, if2.ALUSrc,
                  if2.RegWrite, if2.Jump, if2.PCWrite, if2.IRWrite, if2.IorD};
  assign cw[3] = {if3.aluop, if3.Branch, if3.MemRead, if3.MemtoReg, if3.MemWrite, if3.ALUSrc,
                  if3.RegWrite, if3.Jump, if3.PCWrite, if3.IRWrite, if3.IorD};
  assign er[0] = if0.err;
  assign er[1] = if1.err;
  assign er[2] = if2.err;
  assign er[3] = if3.err;
  assign ic[0] = if0.instr_count;
  assign ic[1] = if1.instr_count;
  assign ic[2] = if2.instr_count;
  assign ic[3] = 32'(if3.instr_count);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset all units and step them into their first FETCH cycle
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b0;
    opcode = OP_BAD;
    repeat (3) tick();
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_cw%0d", d), 32'(cw[d]), 32'd0);
      chk($sformatf("rst_err%0d", d), 32'(er[d]), 32'd0);
      chk($sformatf("rst_cnt%0d", d), ic[d], 32'd0);
    end
    rst_n = 1'b1;
    #1 chk("idle_cw", 32'(cw[0]), 32'd0);
    tick();
    #1 chk("fetch1_cw", 32'(cw[0]), 32'(W_FETCH));
  endtask

  task automatic push(input logic [11:0] w, input logic r);
    wq.push_back(w);
    rq.push_back(r);
  endtask

  // Expected per-cycle control words and the mem_ready schedule for one instruction
  task automatic model_instr(input logic [6:0] op, input logic z, input int fs, input int ms);
    wq.delete();
    rq.delete();
    for (int i = 0; i < fs; i++) push(W_MR, 1'b0);
    push(W_FETCH, 1'b1);
    push(12'h000, 1'($urandom_range(0, 1)));
    case (op)
      OP_R: begin
        push(A_R, 1'($urandom_range(0, 1)));
        push(A_R | W_RW, 1'($urandom_range(0, 1)));
      end
      OP_I: begin
        push(A_I | W_ASRC, 1'($urandom_range(0, 1)));
        push(A_I | W_ASRC | W_RW, 1'($urandom_range(0, 1)));
      end
      OP_ST: begin
        push(W_ASRC, 1'($urandom_range(0, 1)));
        for (int i = 0; i < ms; i++) push(W_MW | W_IORD, 1'b0);
        push(W_MW | W_IORD, 1'b1);
      end
      OP_LD: begin
        push(W_ASRC, 1'($urandom_range(0, 1)));
        for (int i = 0; i < ms; i++) push(W_MR | W_IORD, 1'b0);
        push(W_MR | W_IORD, 1'b1);
        push(W_RW | W_M2R, 1'($urandom_range(0, 1)));
      end
      OP_BR:   push(W_BR | A_BR | (z ? W_PCW : 12'h000), 1'($urandom_range(0, 1)));
      default: push(W_JMP | W_PCW | W_RW, 1'($urandom_range(0, 1)));
    endcase
  endtask

  task automatic run_model(input logic [6:0] op, input logic z, input int fs, input int ms,
                           input string name);
    model_instr(op, z, fs, ms);
    opcode = op;
    zero = z;
    for (int i = 0; i < wq.size(); i++) begin
      mem_ready = rq[i];
      #1 chk($sformatf("%s_c%0d", name, i), 32'(cw[0]), 32'(wq[i]));
      tick();
    end
    model_retired++;
  endtask

  initial begin
    vec_t       tbl[7];
    logic [6:0] legal_ops[6];
    int         lat;
    logic [11:0] last;
    logic       done;

    tbl[0] = '{OP_R,   1'b0, 4, A_R | W_RW};
    tbl[1] = '{OP_I,   1'b0, 4, A_I | W_ASRC | W_RW};
    tbl[2] = '{OP_ST,  1'b0, 4, W_MW | W_IORD};
    tbl[3] = '{OP_LD,  1'b0, 5, W_RW | W_M2R};
    tbl[4] = '{OP_BR,  1'b1, 3, W_BR | A_BR | W_PCW};
    tbl[5] = '{OP_BR,  1'b0, 3, W_BR | A_BR};
    tbl[6] = '{OP_JAL, 1'b0, 3, W_JMP | W_PCW | W_RW};
    legal_ops[0] = OP_R;  legal_ops[1] = OP_I;  legal_ops[2] = OP_LD;
    legal_ops[3] = OP_ST; legal_ops[4] = OP_BR; legal_ops[5] = OP_JAL;

    do_reset();

    // Instruction mix with memory always ready: latency and final-state word
    foreach (tbl[t]) begin
      opcode = tbl[t].op;
      zero = tbl[t].z;
      mem_ready = 1'b1;
      #1 chk($sformatf("mix%0d_fetch", t), 32'(cw[0]), 32'(W_FETCH));
      lat = 1;
      last = 12'h000;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
        tick();
        #1;
        if (cw[0][8] && !cw[0][0]) done = 1'b1;
        else begin
          lat++;
          last = cw[0];
        end
      end
      chk($sformatf("mix%0d_returned", t), 32'(done), 32'd1);
      chk($sformatf("mix%0d_lat", t), 32'(lat), 32'(tbl[t].lat));
      chk($sformatf("mix%0d_last", t), 32'(last), 32'(tbl[t].last));
    end
    chk("mix_cnt0", ic[0], 32'd7);
    chk("mix_cnt3", ic[3], 32'd7);
    model_retired = 7;

    // Randomized instructions and stalls against the trace model
    for (int n = 0; n < 30; n++) begin
      run_model(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end
    chk("rnd_cnt0", ic[0], 32'(model_retired));
    chk("rnd_cnt3", ic[3], 32'(model_retired % 8));
    chk("rnd_err0", 32'(er[0]), 32'd0);

    // Load with 5 fetch stalls and 3 read stalls: 13-cycle trace
    run_model(OP_LD, 1'b0, 5, 3, "stall_ld");
    chk("stall_cnt0", ic[0], 32'(model_retired));
    chk("stall_err0", 32'(er[0]), 32'd0);

    // Store stuck in MEM_WRITE, then illegal opcode, then an R-type
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      mem_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
      opcode = (c < 8) ? OP_ST : ((c < 12) ? OP_BAD : OP_R);
      #1;
      if (c == 6) chk("to_wait1", 32'(cw[1]), 32'(W_MW | W_IORD));
      if (c == 7) begin
        chk("to_halt1", 32'(cw[1]), 32'd0);
        chk("to_err1", 32'(er[1]), 32'd2);
        chk("to_wait0", 32'(cw[0]), 32'(W_MW | W_IORD));
      end
      if (c == 12) begin
        chk("ill_err0", 32'(er[0]), 32'd1);
        chk("ill_halt0", 32'(cw[0]), 32'd0);
      end
      if (c == 16) begin
        chk("end_cw0", 32'(cw[0]), 32'd0);
        chk("end_err0", 32'(er[0]), 32'd1);
        chk("end_cnt0", ic[0], 32'd1);
        chk("end_cw1", 32'(cw[1]), 32'd0);
        chk("end_err1", 32'(er[1]), 32'd2);
        chk("end_cnt1", ic[1], 32'd0);
        chk("end_cw2", 32'(cw[2]), 32'(W_FETCH));
        chk("end_err2", 32'(er[2]), 32'd1);
        chk("end_cnt2", ic[2], 32'd2);
      end
      tick();
    end

    // Counter wrap at CNT_W=3, then asynchronous reset in the middle of MEM_READ
    do_reset();
    model_retired = 0;
    for (int n = 0; n < 9; n++) run_model(OP_JAL, 1'b0, 0, 0, $sformatf("wrap%0d", n));
    chk("wrap_cnt0", ic[0], 32'd9);
    chk("wrap_cnt3", ic[3], 32'd1);
    opcode = OP_LD;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    #1 chk("mr_cw0", 32'(cw[0]), 32'(W_MR | W_IORD));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cw0", 32'(cw[0]), 32'd0);
    chk("arst_cnt0", ic[0], 32'd0);
    chk("arst_cnt3", ic[3], 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RISC-V main control decoder.
- Sequences each instruction (R, I-ALU, load, store, branch, JAL) through a Moore FSM.
- Stalls on a memory ready handshake, detects illegal opcodes and memory timeouts, and counts retired instructions.
- Sits between the instruction register (opcode source) and the shared-memory multi-cycle datapath.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TIMEOUT, 16, max wait cycles for mem_ready in any memory state; 0 disables timeout.
- HALT_ON_ILLEGAL, 1, 1: illegal opcode halts the FSM; 0: the instruction is skipped and fetch resumes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instr[6:0] from IR; stable from the cycle after IRWrite.
- zero  in  1  ALU zero flag, for the branch decision.
- mem_ready  in  1  memory completes the current access this cycle.
- aluop  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct.
- Branch  out  1  branch instruction in progress.
- MemRead  out  1  memory read request.
- MemtoReg  out  1  write-back source is memory data.
- MemWrite  out  1  memory write request.
- ALUSrc  out  1  ALU B operand is the immediate.
- RegWrite  out  1  register file write.
- Jump  out  1  PC source is the jump target.
- PCWrite  out  1  PC register update.
- IRWrite  out  1  instruction register load.
- IorD  out  1  memory address source: 0 = PC, 1 = ALU result.
- err  out  2  sticky error code: 00 none, 01 illegal opcode, 10 timeout.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- All outputs are Moore, decoded from the registered state; the only exception is the gating listed per state. No combinational path from opcode to outputs.
- Reset (rst_n=0, async): state IDLE, wait counter 0, err=00, instr_count=0. All control outputs are 0 during reset and in IDLE.
- IDLE -> FETCH on the first clk edge after rst_n rises.
- FETCH: MemRead=1, IorD=0.
  - IRWrite=mem_ready, PCWrite=mem_ready (PC+4).
  - Stays in FETCH until mem_ready, then -> DECODE.
- DECODE: no outputs asserted. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> ILLEGAL
- EXEC_R: aluop=10, ALUSrc=0 -> WB_ALU.
- EXEC_I: aluop=11, ALUSrc=1 -> WB_ALU.
- WB_ALU: RegWrite=1, MemtoReg=0; aluop and ALUSrc are held from the preceding EXEC state -> FETCH.
- MEM_ADDR: aluop=00, ALUSrc=1. Goes to MEM_READ if the opcode is a load, else MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Waits for mem_ready, then -> WB_MEM.
- MEM_WRITE: MemWrite=1, IorD=1. Waits for mem_ready, then -> FETCH.
- WB_MEM: RegWrite=1, MemtoReg=1 -> FETCH.
- BRANCH: Branch=1, aluop=01, ALUSrc=0, PCWrite=zero -> FETCH.
- JAL: Jump=1, PCWrite=1, RegWrite=1, MemtoReg=0 -> FETCH.
- ILLEGAL (one cycle): err=01 set.
  - HALT_ON_ILLEGAL=1 -> HALT.
  - HALT_ON_ILLEGAL=0 -> FETCH; the instruction is not counted.
- HALT: all outputs 0. Leaves only on reset.
- Latency with mem_ready high every cycle, from FETCH entry to next FETCH entry:
  - R / I / store: 4 cycles
  - load: 5 cycles
  - branch / JAL: 3 cycles
- Timeout:
  - The wait counter clears on entry to FETCH, MEM_READ and MEM_WRITE, and increments each cycle mem_ready=0 in those states.
  - If the counter reaches TIMEOUT while mem_ready=0, the next state is HALT and err=10.
  - If mem_ready=1 in the same cycle the counter reaches TIMEOUT, mem_ready wins.
- err is sticky. The first error wins: a later error does not overwrite a nonzero err.
- instr_count increments by 1 on each transition into FETCH from WB_ALU, WB_MEM, MEM_WRITE, BRANCH or JAL. It wraps from 2^CNT_W-1 to 0.
- rst_n asserted in any state, including mid-wait or HALT, immediately forces the reset values.
- mem_ready is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with mem_ready=1 -> all outputs 0 in reset and IDLE; FETCH on cycle 1 with MemRead=1, IRWrite=1, PCWrite=1.
- Instruction mix, mem_ready=1 throughout:
  - Sequence R, I, store, load, B (zero=1), B (zero=0), JAL -> per-state outputs as specified; cycle counts 4, 4, 4, 5, 3, 3, 3.
  - PCWrite=1 in BRANCH only for zero=1.
  - instr_count=7 at the end.
- Memory stall: load with mem_ready low for 5 cycles in FETCH and 3 cycles in MEM_READ -> MemRead held high throughout, IRWrite only on the ready cycle; total latency 13 cycles; err=00.
- Timeout: TIMEOUT=4, mem_ready stuck 0 in MEM_WRITE -> HALT after 4 wait cycles, err=10. A subsequent illegal opcode does not change err; the block recovers only via rst_n.
- Illegal opcode 0000000:
  - HALT_ON_ILLEGAL=1 -> err=01, FSM stuck in HALT, instr_count unchanged.
  - HALT_ON_ILLEGAL=0 -> err=01, fetch resumes; the following R-type retires normally.
- Counter wrap and async reset: with CNT_W=3, retire 9 instructions -> instr_count=1. Assert rst_n mid-MEM_READ -> outputs 0 immediately, without waiting for a clk edge.
